frame_buffer: RTL and testbench
===============================

# frame_buffer

Show-ahead FIFO of 128-bit trace frames between the frame packer and the SPI uploader. Frames from the packer are stored in block RAM. The head frame is presented on `Frame` with `FrameReady`. The uploader consumes frames with single-cycle `FrameNext` pulses and reads the live occupancy on `FramesCnt`. When the buffer is full, incoming frames are dropped and counted, so that host software can detect lost trace data.

## Interface
Parameters:
- `BUFFLENLOG2`, default 9: log2 of storage slots. Capacity is 2^BUFFLENLOG2−1 frames, so the count always fits in `FramesCnt`.

Ports:
- `clk` input 1: single clock for the whole block.
- `rst` input 1: synchronous, active-low reset (asserted when 0, sampled on rising `clk`).
- `FrameIn` input 128: frame from the packer.
- `FrameInValid` input 1: one-cycle strobe; `FrameIn` is valid this cycle.
- `Flush` input 1: synchronous empty request.
- `Frame` output 128: head frame; valid only while `FrameReady`=1.
- `FrameReady` output 1: head frame is available.
- `FrameNext` input 1: one-cycle pulse; consume the head frame.
- `FramesCnt` output BUFFLENLOG2: number of frames held, including the head.
- `Overflow` output 1: one-cycle pulse; an incoming frame was dropped.
- `LostCnt` output 16: dropped-frame count, saturating.

## Operation
- **Storage:** a RAM of 2^BUFFLENLOG2 words with a registered read, plus one output register (`Frame`). Write and read pointers are BUFFLENLOG2 bits and wrap modulo 2^BUFFLENLOG2.
- **Occupancy:**
  - `FramesCnt` is a registered count of frames in the RAM plus the output register.
  - Full is `FramesCnt` == 2^BUFFLENLOG2−1.
  - Empty is `FramesCnt` == 0.
- **Push:** `FrameInValid`=1 and not full.
  - `FrameIn` is written at the write pointer, which then increments.
  - `FramesCnt` increments by 1.
- **Drop:** `FrameInValid`=1, full, and no pop in the same cycle.
  - The frame is discarded and no state except the loss counters changes.
  - `Overflow` pulses.
  - `LostCnt` increments, saturating at 16'hFFFF.
- **Pop:** `FrameNext`=1 and `FrameReady`=1.
  - The head frame is retired and `FramesCnt` decrements by 1.
  - `FrameNext` while `FrameReady`=0 is ignored: no count change and no error.
- **Simultaneous push and pop:**
  - `FramesCnt` is unchanged.
  - A push while full is accepted, because the pop frees a slot; no `Overflow`.
- **Prefetch:**
  - A RAM read is issued whenever the RAM holds at least one frame and either the output register is empty or is being popped this cycle.
  - The output register loads on the next cycle and `FrameReady` is set.
  - `FrameReady` clears when the head is popped and no prefetch is in flight.
- **Flush:**
  - Pointers, `FramesCnt` and `FrameReady` are cleared, and `LostCnt` is cleared.
  - Flush has priority over push and pop in the same cycle; both are discarded.
  - `Overflow` does not pulse during a flush.
- **Reset (`rst`=0):**
  - `FrameReady`=0, `FramesCnt`=0, `Overflow`=0, `LostCnt`=0.
  - `Frame`=128'h0 and pointers are 0.
  - RAM contents are don't-care.
  - Reset mid-transfer abandons all stored frames.

## Timing
- **Push latency:**
  - A push in cycle N is reflected in `FramesCnt` at N+1.
  - Into an empty buffer: RAM write at N, read at N+1, `Frame`/`FrameReady` valid at N+2.
- **Pop latency:**
  - A pop at N updates `FramesCnt` at N+1.
  - The next head appears on `Frame` at N+1 if the RAM was non-empty at N; otherwise `FrameReady`=0 at N+1.
- **Back-to-back pops:** `FrameNext` may be asserted on consecutive cycles and is honoured each cycle while `FrameReady`=1.
- **Read-during-write to the same RAM address:** cannot occur. The prefetch only reads entries whose write has completed, so the write pointer is never equal to the read address at a read.
- **`Overflow`:** asserted in cycle N+1 for a drop decided in cycle N; exactly one cycle per dropped frame.
- **`FramesCnt` during the prefetch gap:** `FramesCnt` may be non-zero while `FrameReady`=0 for at most one cycle (the in-flight prefetch). The consumer must gate on `FrameReady`, not on `FramesCnt`.

## Test plan
- **Reset values:** hold `rst`=0 for 3 cycles with `FrameInValid`=1 → all outputs stay at their reset values. Release reset, push 128'h1 at cycle N → `FramesCnt`=1 at N+1; `FrameReady`=1 and `Frame`=128'h1 at N+2.
- **Ordered drain:** push 10 frames with values 1..10, then pulse `FrameNext` each cycle while `FrameReady` → `Frame` presents 1..10 in order; `FramesCnt` steps 10→0; `FrameReady`=0 after the tenth pop. One `FrameNext` with `FrameReady`=0 → no change.
- **Full and overflow:**
  - With BUFFLENLOG2=4, push 17 frames → `FramesCnt` saturates at 15; frames 16 and 17 are dropped; two `Overflow` pulses; `LostCnt`=2.
  - Drain → exactly frames 1..15 come out.
- **Simultaneous push and pop when full:** at `FramesCnt`=15, push and pop in the same cycle → count stays 15, no `Overflow`, and the new frame emerges last.
- **Pointer wrap:** with BUFFLENLOG2=4, run 100 interleaved push/pop pairs at random spacing → data stays in order across wrap and `FramesCnt` never exceeds 15.
- **Flush and loss-count saturation:**
  - `Flush` while holding 5 frames, with a push in the same cycle → `FramesCnt`=0, `FrameReady`=0, `LostCnt`=0 next cycle; the subsequent push is the first frame out.
  - Force 70000 drops → `LostCnt` holds at 16'hFFFF.

Source files
------------

// File: rtl/frame_buffer.sv
// Show-ahead FIFO of 128-bit trace frames, block-RAM backed, with one output register.
// Frames arriving while full are dropped and counted in a saturating loss counter.
module frame_buffer #(
    parameter int BUFFLENLOG2 = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [127:0]           FrameIn,
    input  logic                   FrameInValid,
    input  logic                   Flush,
    output logic [127:0]           Frame,
    output logic                   FrameReady,
    input  logic                   FrameNext,
    output logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic                   Overflow,
    output logic [15:0]            LostCnt
);

    localparam int                     DEPTH    = 2 ** BUFFLENLOG2;
    localparam logic [BUFFLENLOG2-1:0] FULL_CNT = '1;
    localparam logic [BUFFLENLOG2-1:0] PTR_ONE  = BUFFLENLOG2'(1);

    logic [127:0]           r_mem [0:DEPTH-1];
    logic [BUFFLENLOG2-1:0] r_wr_ptr;
    logic [BUFFLENLOG2-1:0] r_rd_ptr;
    logic [BUFFLENLOG2-1:0] r_cnt;
    logic                   r_ready;
    logic [127:0]           r_frame;
    logic                   r_overflow;
    logic [15:0]            r_lost;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [BUFFLENLOG2-1:0] w_ram_cnt;
    logic                   w_rd;

    assign w_full    = (r_cnt == FULL_CNT);
    assign w_pop     = FrameNext && r_ready;
    // A pop frees a slot in the same cycle, so a push while full is still accepted.
    assign w_push    = FrameInValid && (!w_full || w_pop) && !Flush;
    assign w_drop    = FrameInValid && w_full && !w_pop;
    // Frames written but not yet moved into the output register.
    assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
    // Reads only target completed writes, so the read address never equals the write pointer.
    assign w_rd      = (w_ram_cnt != '0) && (!r_ready || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= FrameIn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_frame    <= '0;
            r_overflow <= 1'b0;
            r_lost     <= '0;
        end else if (Flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
            r_lost     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            // The registered RAM read is the output register itself.
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_frame  <= r_mem[r_rd_ptr];
                r_ready  <= 1'b1;
            end else if (w_pop) begin
                r_ready  <= 1'b0;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + PTR_ONE;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - PTR_ONE;
            end
            r_overflow <= w_drop;
            if (w_drop && (r_lost != 16'hFFFF)) begin
                r_lost <= r_lost + 16'd1;
            end
        end
    end

    assign Frame      = r_frame;
    assign FrameReady = r_ready;
    assign FramesCnt  = r_cnt;
    assign Overflow   = r_overflow;
    assign LostCnt    = r_lost;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed plus random bench for frame_buffer (capacity 15) against a queue-based model
// of accepted frames, occupancy, drop pulses and the saturating loss count.
module tb_frame_buffer;

    localparam int L   = 4;
    localparam int CAP = (2 ** L) - 1;

    logic           clk;
    logic           rst;
    logic [127:0]   FrameIn;
    logic           FrameInValid;
    logic           Flush;
    logic [127:0]   Frame;
    logic           FrameReady;
    logic           FrameNext;
    logic [L-1:0]   FramesCnt;
    logic           Overflow;
    logic [15:0]    LostCnt;

    frame_buffer #(.BUFFLENLOG2(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .FrameIn      (FrameIn),
        .FrameInValid (FrameInValid),
        .Flush        (Flush),
        .Frame        (Frame),
        .FrameReady   (FrameReady),
        .FrameNext    (FrameNext),
        .FramesCnt    (FramesCnt),
        .Overflow     (Overflow),
        .LostCnt      (LostCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] exp_q[$];
    logic         exp_ovf;
    int           exp_lost;
    logic [127:0] last_out;
    int           n_out;
    int           n_ovf_seen;
    int           gap_run;
    int           n_checks;
    int           n_fail;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then check outputs after the edge.
    task automatic cycle(input logic v, input logic [127:0] d, input logic nx, input logic fl);
        logic pop;
        logic full;
        FrameInValid = v;
        FrameIn      = d;
        FrameNext    = nx;
        Flush        = fl;
        pop  = nx && FrameReady;
        full = (exp_q.size() == CAP);
        if (fl) begin
            exp_q.delete();
            exp_lost = 0;
            exp_ovf  = 1'b0;
        end else begin
            exp_ovf = 1'b0;
            if (pop && exp_q.size() > 0) begin
                last_out = exp_q.pop_front();
                n_out++;
            end
            if (v && (!full || pop)) begin
                exp_q.push_back(d);
            end else if (v) begin
                exp_ovf = 1'b1;
                if (exp_lost < 65535) exp_lost++;
            end
        end
        @(posedge clk);
        #1;
        chk("frames_cnt", 128'(FramesCnt), 128'(exp_q.size()));
        chk("overflow", 128'(Overflow), 128'(exp_ovf));
        chk("lost_cnt", 128'(LostCnt), 128'(exp_lost));
        if (Overflow) n_ovf_seen++;
        if (FrameReady) begin
            chk("ready_nonempty", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) chk("head_frame", Frame, exp_q[0]);
        end
        if (FramesCnt != '0 && !FrameReady) gap_run++;
        else gap_run = 0;
        chk("prefetch_gap", 128'(gap_run <= 1), 128'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0 && !FrameReady) break;
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_cnt", 128'(FramesCnt), 128'(0));
        chk("drain_ready", 128'(FrameReady), 128'(0));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_ovf = 1'b0; exp_lost = 0;
        n_out = 0; n_ovf_seen = 0; gap_run = 0; last_out = '0;
        rst = 1'b0; FrameInValid = 1'b1; FrameIn = 128'hDEAD; FrameNext = 1'b0; Flush = 1'b0;

        // Reset held with FrameInValid asserted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 128'(FrameReady), 128'(0));
            chk("rst_cnt", 128'(FramesCnt), 128'(0));
            chk("rst_ovf", 128'(Overflow), 128'(0));
            chk("rst_lost", 128'(LostCnt), 128'(0));
            chk("rst_frame", Frame, 128'h0);
        end
        rst = 1'b1;

        // First push latency.
        cycle(1'b1, 128'h1, 1'b0, 1'b0);
        chk("lat_cnt_n1", 128'(FramesCnt), 128'(1));
        chk("lat_ready_n1", 128'(FrameReady), 128'(0));
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("lat_ready_n2", 128'(FrameReady), 128'(1));
        chk("lat_frame_n2", Frame, 128'h1);
        drain();

        // Ordered drain of 1..10.
        n_out = 0;
        for (int i = 1; i <= 10; i++) cycle(1'b1, 128'(i), 1'b0, 1'b0);
        drain();
        chk("drain10_count", 128'(n_out), 128'(10));
        chk("drain10_last", last_out, 128'd10);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("idle_next_cnt", 128'(FramesCnt), 128'(0));
        chk("idle_next_ready", 128'(FrameReady), 128'(0));

        // Fill past capacity: two drops.
        n_ovf_seen = 0;
        for (int i = 1; i <= 17; i++) cycle(1'b1, 128'(100 + i), 1'b0, 1'b0);
        chk("full_cnt", 128'(FramesCnt), 128'(CAP));
        chk("full_lost", 128'(LostCnt), 128'(2));
        chk("full_ovf_pulses", 128'(n_ovf_seen), 128'(2));

        // Push and pop together while full.
        cycle(1'b1, 128'd200, 1'b1, 1'b0);
        chk("pp_full_cnt", 128'(FramesCnt), 128'(CAP));
        chk("pp_full_ovf", 128'(Overflow), 128'(0));
        n_out = 0;
        drain();
        chk("pp_drain_count", 128'(n_out), 128'(CAP));
        chk("pp_drain_last", last_out, 128'd200);

        // Random interleaving across pointer wrap, including drops.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 6), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'b0);
        end
        drain();

        // Flush with a simultaneous push.
        for (int i = 0; i < 5; i++) cycle(1'b1, 128'(300 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 128'd999, 1'b0, 1'b1);
        chk("flush_cnt", 128'(FramesCnt), 128'(0));
        chk("flush_ready", 128'(FrameReady), 128'(0));
        chk("flush_lost", 128'(LostCnt), 128'(0));
        cycle(1'b1, 128'h55, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("post_flush_ready", 128'(FrameReady), 128'(1));
        chk("post_flush_frame", Frame, 128'h55);
        drain();

        // Loss counter saturation.
        for (int i = 0; i < CAP; i++) cycle(1'b1, 128'(500 + i), 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) cycle(1'b1, 128'(i), 1'b0, 1'b0);
        chk("lost_saturated", 128'(LostCnt), 128'h0000_FFFF);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("lost_hold", 128'(LostCnt), 128'h0000_FFFF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
